// File: rtl/aes_pkg.sv
// Shared types, constants and helpers for the iterative AES-128 round sequencer.
package aes_pkg;

  localparam int unsigned AES128_NROUNDS = 10;
  localparam int unsigned ROUND_W        = 4;
  localparam int unsigned COL_W          = 2;
  localparam int unsigned RCON_W         = 8;
  localparam logic [RCON_W-1:0] RCON_INIT = 8'h01;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    SUBKEY,
    SUBCOL,
    COMMIT,
    DONE
  } ctrl_state_t;

  // GF(2^8) multiply by x, reduced by the AES polynomial.
  function automatic logic [RCON_W-1:0] xtime(input logic [RCON_W-1:0] b);
    return {b[RCON_W-2:0], 1'b0} ^ (b[RCON_W-1] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_rcon.sv
// Round-constant register: reloads on init, advances by xtime on step.
module aes_rcon
  import aes_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        init,
  input  logic        step,
  output logic [7:0]  rcon
);

  always_ff @(posedge clk) begin
    if (reset || init) begin
      rcon <= RCON_INIT;
    end else if (step) begin
      rcon <= xtime(rcon);
    end
  end

endmodule

// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: steps the datapath through INIT, ten rounds and
// completion while time-sharing one S-box bank between key and state.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned NROUNDS = AES128_NROUNDS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        state_init,
  output logic        sbox_sel,
  output logic [1:0]  col_idx,
  output logic        key_we,
  output logic        col_we,
  output logic        round_we,
  output logic        mix_en,
  output logic [7:0]  rcon,
  output logic [3:0]  round
);

  ctrl_state_t state, state_nxt;
  logic        last_round;
  logic        last_col;
  logic        rcon_init;
  logic        rcon_step;

  assign last_round = (round == ROUND_W'(NROUNDS));
  assign last_col   = (col_idx == COL_W'(3));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; start is only honoured when not busy.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = INIT;
      INIT:    state_nxt = SUBKEY;
      SUBKEY:  state_nxt = SUBCOL;
      SUBCOL:  if (last_col) state_nxt = COMMIT;
      COMMIT:  state_nxt = last_round ? DONE : SUBKEY;
      DONE:    if (start) state_nxt = INIT;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore strobes decoded from the state register only.
  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    state_init = 1'b0;
    sbox_sel   = 1'b0;
    key_we     = 1'b0;
    col_we     = 1'b0;
    round_we   = 1'b0;
    mix_en     = 1'b0;
    rcon_init  = 1'b0;
    rcon_step  = 1'b0;
    unique case (state)
      INIT: begin
        busy       = 1'b1;
        state_init = 1'b1;
        rcon_init  = 1'b1;
      end
      SUBKEY: begin
        busy   = 1'b1;
        key_we = 1'b1;
      end
      SUBCOL: begin
        busy     = 1'b1;
        sbox_sel = 1'b1;
        col_we   = 1'b1;
      end
      COMMIT: begin
        busy      = 1'b1;
        round_we  = 1'b1;
        mix_en    = !last_round;
        rcon_step = !last_round;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Round and column counters; round only restarts through INIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      round   <= '0;
      col_idx <= '0;
    end else begin
      unique case (state)
        INIT:    round   <= ROUND_W'(1);
        SUBKEY:  col_idx <= '0;
        SUBCOL:  col_idx <= col_idx + COL_W'(1);
        COMMIT:  if (!last_round) round <= round + ROUND_W'(1);
        default: ;
      endcase
    end
  end

  aes_rcon u_rcon (
    .clk   (clk),
    .reset (reset),
    .init  (rcon_init),
    .step  (rcon_step),
    .rcon  (rcon)
  );

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Sequencer for the iterative AES-128 encryption core. It steps the datapath through the initial AddRoundKey, rounds 1–10 and completion. A single 4-byte S-box bank is time-shared between key-schedule SubWord and state SubBytes, and this block arbitrates its use. It sits between the SPI front end, which supplies `start` once 256 bits are shifted in, and the state/key registers, and it produces the `done` level the front end polls before shifting out ciphertext.

## Interface
- `NROUNDS`, default 10: number of cipher rounds; only 10 (AES-128) is supported.
- `clk`  in  1  core clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  level/pulse; sampled only in IDLE or DONE.
- `busy`  out  1  high from INIT through the last COMMIT.
- `done`  out  1  ciphertext valid; held until next accepted `start` or `reset`.
- `state_init`  out  1  datapath loads plaintext XOR key into state, key into round-key register.
- `sbox_sel`  out  1  S-box bank input mux: 0 = key word w3 rotated, 1 = state column.
- `col_idx`  out  2  state column fed to S-box bank when `sbox_sel`=1.
- `key_we`  out  1  round-key register captures next round key (uses S-box output and `rcon`).
- `col_we`  out  1  substituted column `col_idx` written back to state.
- `round_we`  out  1  state <= AddRoundKey(MixColumns?(ShiftRows(state))).
- `mix_en`  out  1  MixColumns enabled for `round_we`; 0 in final round.
- `rcon`  out  8  round constant for the current key step.
- `round`  out  4  current round number, 0–10.

## Operation
- States: IDLE, INIT, SUBKEY, SUBCOL, COMMIT, DONE.
- IDLE: all strobes 0. `start`=1 -> INIT.
- INIT, 1 cycle: `state_init`=1, `busy`=1, `round`<=1 on exit, `rcon`<=8'h01 -> SUBKEY.
- SUBKEY, 1 cycle: `sbox_sel`=0, `key_we`=1 -> SUBCOL with `col_idx`=0.
- SUBCOL, 4 cycles: `sbox_sel`=1, `col_we`=1, `col_idx` 0,1,2,3 -> COMMIT.
- COMMIT, 1 cycle: `round_we`=1, `mix_en`=(`round`!=10). If `round`==10 -> DONE. Otherwise `round`+=1, `rcon`<=xtime(`rcon`) (left shift, XOR 8'h1B on carry-out) -> SUBKEY.
- `rcon` sequence per round: 01,02,04,08,10,20,40,80,1B,36.
- DONE: `done`=1, `busy`=0, all strobes 0. `start`=1 -> INIT and `done` deasserts the same edge.
- Arbitration: exactly one S-box consumer per cycle. `key_we` and `col_we` are never both high. Key step always precedes the column steps within a round, because AddRoundKey in COMMIT needs the new key.
- `start` while `busy` is ignored and does not queue.
- Strobes are Moore outputs decoded from the state register only; no combinational path from `start`.

## Timing
- Reset values: state IDLE; `busy`=0, `done`=0, `rcon`=8'h01, `round`=0, `col_idx`=0, all strobes 0.
- Per round: 6 cycles (1 SUBKEY + 4 SUBCOL + 1 COMMIT).
- Latency: `start` sampled at edge E0 puts the FSM in INIT. `done` is first high after edge E0+61 (1 INIT + 10×6).
- `reset` mid-operation returns to IDLE on the next edge regardless of state. `done` clears and no further datapath strobes are issued.
- `reset` and `start` high together: `reset` wins.
- `round` wraps only via INIT; it never exceeds 10.

## Structure
- `aes_pkg`: state enum `ctrl_state_t`, `RCON_INIT`=8'h01, `xtime()` function, `AES128_NROUNDS`=10.
- Sub-module `aes_rcon`: 8-bit rcon register with `init` and `step` inputs, built on `xtime`.
- FSM, round counter and column counter live in `aes_round_ctrl`.

## Test plan
- Reset, then idle 5 cycles -> all outputs at reset values; `busy`=0, `done`=0.
- `start` for 1 cycle -> INIT next cycle. Exactly 10 `key_we`, 40 `col_we` (`col_idx` 0..3 repeating) and 10 `round_we` pulses; `mix_en`=0 only on the 10th `round_we`; `done` high 61 cycles after `start`.
- Capture `rcon` at each `key_we` -> 01,02,04,08,10,20,40,80,1B,36.
- Pulse `start` again at cycles 10 and 30 of a run -> no effect, `done` still at 61. Hold `start` in DONE -> new run begins, `done` drops.
- Assert `reset` during round 5 SUBCOL -> next cycle IDLE, all strobes 0, `rcon`=01. A following `start` completes normally in 61 cycles.
- Integration with the datapath: key 000102030405060708090A0B0C0D0E0F, plaintext 00112233445566778899AABBCCDDEEFF -> ciphertext 69C4E0D86A7B0430D8CDB78070B4C55A when `done` rises.
